// File: rtl/sdram_port_arbiter_if.sv
// Bundle between the requester ports, the arbiter and the SDRAM core command port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sdram_port_arbiter_if #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_LEN   = DATA_WIDTH / 8
);
  logic [N_PORTS-1:0]            s_rd;
  logic [N_PORTS*WORD_LEN-1:0]   s_wr;
  logic [N_PORTS*ADDR_WIDTH-1:0] s_addr;
  logic [N_PORTS*DATA_WIDTH-1:0] s_write_data;
  logic [N_PORTS-1:0]            s_rdy;
  logic [N_PORTS-1:0]            s_rvalid;
  logic [N_PORTS-1:0]            s_wvalid;
  logic [N_PORTS-1:0]            s_error;
  logic [DATA_WIDTH-1:0]         s_read_data;

  logic                          m_rd;
  logic [WORD_LEN-1:0]           m_wr;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic [DATA_WIDTH-1:0]         m_write_data;
  logic                          m_rdy;
  logic                          m_rvalid;
  logic                          m_wvalid;
  logic [DATA_WIDTH-1:0]         m_read_data;
  logic                          m_error;

  modport slave (
    input  s_rd, s_wr, s_addr, s_write_data,
    output s_rdy, s_rvalid, s_wvalid, s_error, s_read_data,
    output m_rd, m_wr, m_addr, m_write_data,
    input  m_rdy, m_rvalid, m_wvalid, m_read_data, m_error
  );

  modport master (
    output s_rd, s_wr, s_addr, s_write_data,
    input  s_rdy, s_rvalid, s_wvalid, s_error, s_read_data,
    input  m_rd, m_wr, m_addr, m_write_data,
    output m_rdy, m_rvalid, m_wvalid, m_read_data, m_error
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin (optionally port-0 priority) arbiter sharing one SDRAM core command port;
// one transaction outstanding, response routed to the owner, stuck transactions timed out.
module sdram_port_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_LEN   = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255,
  parameter int PRIO0      = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic                  rd_q, rd_d;
  logic [WORD_LEN-1:0]   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [N_PORTS-1:0]    req;
  logic                  win_vld;
  logic [PW-1:0]         win;
  logic [N_PORTS-1:0]    rdy, rvalid, wvalid, err;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < N_PORTS; i++)
      req[i] = bus.s_rd[i] | (|bus.s_wr[i*WORD_LEN +: WORD_LEN]);
  end

  // Search upward from the rr pointer with wrap; port-0 priority overrides the result.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win     = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      idx = PW'((32'(rr_q) + k) % N_PORTS);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
    if (PRIO0 != 0 && req[0]) win = '0;
  end

  always_comb begin
    int unsigned sel;
    sel          = 32'(win);
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdy          = '0;
    rvalid       = '0;
    wvalid       = '0;
    err          = '0;
    rdata        = '0;
    bus.m_rd         = 1'b0;
    bus.m_wr         = '0;
    bus.m_addr       = '0;
    bus.m_write_data = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          rdy[win] = 1'b1;
          owner_d  = win;
          rr_d     = (win == PW'(N_PORTS - 1)) ? '0 : win + 1'b1;
          rd_d     = bus.s_rd[win];
          wr_d     = bus.s_rd[win] ? '0 : bus.s_wr[sel*WORD_LEN +: WORD_LEN];
          addr_d   = bus.s_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d  = bus.s_write_data[sel*DATA_WIDTH +: DATA_WIDTH];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus.m_rd         = rd_q;
        bus.m_wr         = wr_q;
        bus.m_addr       = addr_q;
        bus.m_write_data = wdata_q;
        if (bus.m_error) begin
          err[owner_q] = 1'b1;
          state_d      = IDLE;
        end else if (bus.m_rdy) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          rvalid[owner_q] = 1'b1;
          rdata           = bus.m_read_data;
          state_d         = IDLE;
        end else if (bus.m_wvalid) begin
          wvalid[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (bus.m_error || cnt_q == CW'(TIMEOUT - 1)) begin
          err[owner_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // s_rdy is the only output that can rise combinationally in reset (IDLE + live requests).
  assign bus.s_rdy       = rdy & {N_PORTS{rst_n}};
  assign bus.s_rvalid    = rvalid;
  assign bus.s_wvalid    = wvalid;
  assign bus.s_error     = err;
  assign bus.s_read_data = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
